// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access modes, error codes, FSM states.
// Latency: none (definitions and pure functions only).
// Backpressure: not applicable.
package load_store_unit_pkg;

   localparam logic [2:0] MEM_MODE_BYTE       = 3'd0;
   localparam logic [2:0] MEM_MODE_BYTE_SIGN  = 3'd1;
   localparam logic [2:0] MEM_MODE_HWORD      = 3'd2;
   localparam logic [2:0] MEM_MODE_HWORD_SIGN = 3'd3;
   localparam logic [2:0] MEM_MODE_WORD       = 3'd4;
   localparam logic [2:0] MEM_MODE_DWORD      = 3'd5;

   localparam logic [1:0] LSU_ERR_OK       = 2'd0;
   localparam logic [1:0] LSU_ERR_MISALIGN = 2'd1;
   localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'd3;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_BUS  = 2'd1,
      LSU_RESP = 2'd2
   } lsu_state_e;

   // DWORD exists only on a 64-bit bus
   function automatic logic lsu_illegal(input logic [2:0] mode, input int data_w);
      return (data_w == 64) ? (mode >= 3'd6) : (mode >= 3'd5);
   endfunction

   // natural alignment check on the low address bits
   function automatic logic lsu_misaligned(input logic [2:0] mode, input logic [2:0] a);
      logic m;
      m = 1'b0;
      case (mode)
         MEM_MODE_HWORD, MEM_MODE_HWORD_SIGN: m = a[0];
         MEM_MODE_WORD:                       m = |a[1:0];
         MEM_MODE_DWORD:                      m = |a[2:0];
         default:                             m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: enables, store data shift, load data extract and extend.
// Latency: combinational.
// Backpressure: none; outputs follow inputs.
module lsu_lane_align
   import load_store_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int NB = DATA_W / 8,
   localparam int LSB = $clog2(DATA_W / 8)
) (
   input  logic [2:0]        mode_i,
   input  logic [LSB-1:0]    off_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [NB-1:0]     byteen_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] mask;
   logic              sbit;

   // lane enables and store shift from the byte offset within the bus word
   always_comb begin
      byteen_o = '1;
      case (mode_i)
         MEM_MODE_BYTE, MEM_MODE_BYTE_SIGN:   byteen_o = NB'(1) << off_i;
         MEM_MODE_HWORD, MEM_MODE_HWORD_SIGN: byteen_o = NB'(3) << off_i;
         MEM_MODE_WORD:                       byteen_o = NB'(4'hF) << off_i;
         default:                             byteen_o = '1;
      endcase
      wdata_o = wdata_i << {off_i, 3'b000};
   end

   // right-justify load data, keep access width, fill upper bits with sign or zero
   always_comb begin
      shifted = rdata_i >> {off_i, 3'b000};
      mask    = '1;
      sbit    = 1'b0;
      case (mode_i)
         MEM_MODE_BYTE:       mask = DATA_W'(8'hFF);
         MEM_MODE_BYTE_SIGN:  begin mask = DATA_W'(8'hFF);   sbit = shifted[7];  end
         MEM_MODE_HWORD:      mask = DATA_W'(16'hFFFF);
         MEM_MODE_HWORD_SIGN: begin mask = DATA_W'(16'hFFFF); sbit = shifted[15]; end
         MEM_MODE_WORD:       begin
            mask = DATA_W'(32'hFFFF_FFFF);
            sbit = (DATA_W == 64) && shifted[31];
         end
         default:             mask = '1;
      endcase
      rdata_o = (shifted & mask) | ({DATA_W{sbit}} & ~mask);
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, lane alignment, misalign/illegal detect, bus timeout.
// Latency: accept -> rsp_valid is 2 cycles plus bus wait states; error paths 1 cycle.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255,
   localparam int LSB = $clog2(DATA_W / 8)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_mode,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [4:0]            req_dst,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_data,
   output logic [4:0]            rsp_dst,
   output logic [1:0]            rsp_err,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_W-LSB-1:0] bus_addr,
   output logic [DATA_W/8-1:0]   bus_byteen,
   output logic [DATA_W-1:0]     bus_wdata,
   input  logic                  bus_ack,
   input  logic [DATA_W-1:0]     bus_rdata
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   lsu_state_e        state_q, state_d;
   logic              write_q, write_d;
   logic [2:0]        mode_q, mode_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [4:0]        dst_q, dst_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        err_q, err_d;

   logic [DATA_W/8-1:0] lane_be;
   logic [DATA_W-1:0]   lane_wdata;
   logic [DATA_W-1:0]   lane_rdata;

   lsu_lane_align #(.DATA_W(DATA_W)) u_align (
      .mode_i   (mode_q),
      .off_i    (addr_q[LSB-1:0]),
      .wdata_i  (wdata_q),
      .rdata_i  (bus_rdata),
      .byteen_o (lane_be),
      .wdata_o  (lane_wdata),
      .rdata_o  (lane_rdata)
   );

   // state, request latches, wait counter and response registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LSU_IDLE;
         write_q <= 1'b0;
         mode_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= LSU_ERR_OK;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // next state: accept and classify in IDLE, wait for ack or timeout in BUS, hand off in RESP
   always_comb begin
      state_d = state_q;
      write_d = write_q;
      mode_d  = mode_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         LSU_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               mode_d  = req_mode;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               dst_d   = req_dst;
               cnt_d   = '0;
               rdata_d = '0;
               if (lsu_illegal(req_mode, DATA_W)) begin
                  err_d   = LSU_ERR_ILLEGAL;
                  state_d = LSU_RESP;
               end else if (lsu_misaligned(req_mode, req_addr[2:0])) begin
                  err_d   = LSU_ERR_MISALIGN;
                  state_d = LSU_RESP;
               end else begin
                  err_d   = LSU_ERR_OK;
                  state_d = LSU_BUS;
               end
            end
         end
         LSU_BUS: begin
            // an ack in the final wait cycle still completes the access
            if (bus_ack) begin
               rdata_d = write_q ? '0 : lane_rdata;
               err_d   = LSU_ERR_OK;
               state_d = LSU_RESP;
            end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
               rdata_d = '0;
               err_d   = LSU_ERR_TIMEOUT;
               state_d = LSU_RESP;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         LSU_RESP: begin
            if (rsp_ready) state_d = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   // outputs decode straight from state so reset clears bus_req and rsp_valid immediately
   always_comb begin
      req_ready  = (state_q == LSU_IDLE);
      rsp_valid  = (state_q == LSU_RESP);
      rsp_data   = rdata_q;
      rsp_dst    = dst_q;
      rsp_err    = err_q;
      bus_req    = (state_q == LSU_BUS);
      bus_we     = bus_req & write_q;
      bus_addr   = addr_q[ADDR_W-1:LSB];
      bus_byteen = bus_req ? lane_be : '0;
      bus_wdata  = lane_wdata;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: 32-bit unit with a short timeout and a 64-bit unit with default timeout.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised by holding rsp_ready low and by back-to-back requests.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // 32-bit instance, TIMEOUT=4
   logic        a_req_valid, a_req_ready, a_req_write;
   logic [2:0]  a_req_mode;
   logic [31:0] a_req_addr, a_req_wdata;
   logic [4:0]  a_req_dst, a_rsp_dst;
   logic        a_rsp_valid, a_rsp_ready;
   logic [31:0] a_rsp_data;
   logic [1:0]  a_rsp_err;
   logic        a_bus_req, a_bus_we, a_bus_ack;
   logic [29:0] a_bus_addr;
   logic [3:0]  a_bus_byteen;
   logic [31:0] a_bus_wdata, a_bus_rdata;

   // 64-bit instance
   logic        b_req_valid, b_req_ready, b_req_write;
   logic [2:0]  b_req_mode;
   logic [31:0] b_req_addr;
   logic [63:0] b_req_wdata;
   logic [4:0]  b_req_dst, b_rsp_dst;
   logic        b_rsp_valid, b_rsp_ready;
   logic [63:0] b_rsp_data;
   logic [1:0]  b_rsp_err;
   logic        b_bus_req, b_bus_we, b_bus_ack;
   logic [28:0] b_bus_addr;
   logic [7:0]  b_bus_byteen;
   logic [63:0] b_bus_wdata, b_bus_rdata;

   load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut_a (
      .clk(clk), .reset(reset),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
      .req_mode(a_req_mode), .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_dst(a_req_dst),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
      .rsp_dst(a_rsp_dst), .rsp_err(a_rsp_err),
      .bus_req(a_bus_req), .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_byteen(a_bus_byteen),
      .bus_wdata(a_bus_wdata), .bus_ack(a_bus_ack), .bus_rdata(a_bus_rdata)
   );

   load_store_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255)) dut_b (
      .clk(clk), .reset(reset),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_mode(b_req_mode), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_dst(b_req_dst),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
      .rsp_dst(b_rsp_dst), .rsp_err(b_rsp_err),
      .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr), .bus_byteen(b_bus_byteen),
      .bus_wdata(b_bus_wdata), .bus_ack(b_bus_ack), .bus_rdata(b_bus_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic req_a(input logic wr, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] dst);
      a_req_valid = 1'b1;
      a_req_write = wr;
      a_req_mode  = mode;
      a_req_addr  = addr;
      a_req_wdata = wdata;
      a_req_dst   = dst;
   endtask

   task automatic req_b(input logic [2:0] mode, input logic [31:0] addr, input logic [4:0] dst);
      b_req_valid = 1'b1;
      b_req_write = 1'b0;
      b_req_mode  = mode;
      b_req_addr  = addr;
      b_req_wdata = '0;
      b_req_dst   = dst;
   endtask

   initial begin
      reset = 1'b1;
      a_req_valid = 0; a_req_write = 0; a_req_mode = 0; a_req_addr = 0; a_req_wdata = 0;
      a_req_dst = 0; a_rsp_ready = 1; a_bus_ack = 0; a_bus_rdata = 0;
      b_req_valid = 0; b_req_write = 0; b_req_mode = 0; b_req_addr = 0; b_req_wdata = 0;
      b_req_dst = 0; b_rsp_ready = 1; b_bus_ack = 0; b_bus_rdata = 0;
      tick();
      tick();

      // reset state
      chk("rst_req_ready", a_req_ready, 1);
      chk("rst_rsp_valid", a_rsp_valid, 0);
      chk("rst_bus_req", a_bus_req, 0);
      chk("rst_bus_we", a_bus_we, 0);
      chk("rst_byteen", a_bus_byteen, 0);
      chk("rst_bus_addr", a_bus_addr, 0);
      chk("rst_bus_wdata", a_bus_wdata, 0);
      chk("rst_rsp_data", a_rsp_data, 0);
      reset = 1'b0;
      tick();

      // signed byte load at 0x103, zero waits, response held 10 cycles
      a_rsp_ready = 1'b0;
      req_a(0, MEM_MODE_BYTE_SIGN, 32'h103, 32'h0, 5'd7);
      chk("ld_b_ready", a_req_ready, 1);
      tick();
      a_req_valid = 1'b0;
      chk("ld_b_bus_req", a_bus_req, 1);
      chk("ld_b_byteen", a_bus_byteen, 4'b1000);
      chk("ld_b_bus_addr", a_bus_addr, 30'h40);
      chk("ld_b_we", a_bus_we, 0);
      chk("ld_b_no_rsp_yet", a_rsp_valid, 0);
      a_bus_ack = 1'b1;
      a_bus_rdata = 32'h80FF_1234;
      tick();
      a_bus_ack = 1'b0;
      a_bus_rdata = 32'h0;
      chk("ld_b_rsp_valid", a_rsp_valid, 1);
      chk("ld_b_rsp_data", a_rsp_data, 32'hFFFF_FF80);
      chk("ld_b_rsp_err", a_rsp_err, 0);
      chk("ld_b_rsp_dst", a_rsp_dst, 7);
      chk("ld_b_bus_idle", a_bus_req, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_valid", a_rsp_valid, 1);
         chk("stall_data", a_rsp_data, 32'hFFFF_FF80);
         chk("stall_req_ready", a_req_ready, 0);
      end
      a_rsp_ready = 1'b1;
      tick();
      chk("stall_done_ready", a_req_ready, 1);
      chk("stall_done_valid", a_rsp_valid, 0);

      // ack while idle is ignored
      a_bus_ack = 1'b1;
      tick();
      a_bus_ack = 1'b0;
      chk("stray_ack_rsp", a_rsp_valid, 0);
      chk("stray_ack_bus", a_bus_req, 0);

      // halfword store at 0x202 with one wait state, then back-to-back misaligned load
      req_a(1, MEM_MODE_HWORD, 32'h202, 32'h0000_ABCD, 5'd3);
      tick();
      a_req_valid = 1'b0;
      chk("st_h_bus_addr", a_bus_addr, 30'h80);
      chk("st_h_byteen", a_bus_byteen, 4'b1100);
      chk("st_h_wdata", a_bus_wdata, 32'hABCD_0000);
      chk("st_h_we", a_bus_we, 1);
      tick();
      chk("st_h_wait_req", a_bus_req, 1);
      chk("st_h_wait_addr", a_bus_addr, 30'h80);
      chk("st_h_wait_wdata", a_bus_wdata, 32'hABCD_0000);
      a_bus_ack = 1'b1;
      a_bus_rdata = 32'hFFFF_FFFF;
      req_a(0, MEM_MODE_WORD, 32'h101, 32'h0, 5'd9);
      tick();
      a_bus_ack = 1'b0;
      chk("st_h_rsp_valid", a_rsp_valid, 1);
      chk("st_h_rsp_data", a_rsp_data, 0);
      chk("st_h_rsp_err", a_rsp_err, 0);
      chk("st_h_rsp_dst", a_rsp_dst, 3);
      chk("b2b_not_ready", a_req_ready, 0);
      tick();
      chk("b2b_ready_after_hs", a_req_ready, 1);
      chk("b2b_rsp_gone", a_rsp_valid, 0);
      tick();
      a_req_valid = 1'b0;
      chk("mis_rsp_valid", a_rsp_valid, 1);
      chk("mis_rsp_err", a_rsp_err, 1);
      chk("mis_rsp_dst", a_rsp_dst, 9);
      chk("mis_no_bus", a_bus_req, 0);
      tick();
      chk("mis_no_bus2", a_bus_req, 0);

      // illegal mode 5 on a 32-bit bus
      req_a(0, 3'd5, 32'h0, 32'h0, 5'd1);
      tick();
      a_req_valid = 1'b0;
      chk("ill_rsp_valid", a_rsp_valid, 1);
      chk("ill_rsp_err", a_rsp_err, 3);
      chk("ill_no_bus", a_bus_req, 0);
      tick();

      // unsigned byte load at 0x101
      req_a(0, MEM_MODE_BYTE, 32'h101, 32'h0, 5'd2);
      tick();
      a_req_valid = 1'b0;
      chk("ld_ub_byteen", a_bus_byteen, 4'b0010);
      a_bus_ack = 1'b1;
      a_bus_rdata = 32'h0000_F000;
      tick();
      a_bus_ack = 1'b0;
      chk("ld_ub_data", a_rsp_data, 32'h0000_00F0);
      tick();

      // word load with no ack: bus_req for exactly 4 cycles then timeout
      req_a(0, MEM_MODE_WORD, 32'h10, 32'h0, 5'd4);
      tick();
      a_req_valid = 1'b0;
      chk("to_byteen", a_bus_byteen, 4'hF);
      for (int i = 0; i < 4; i++) begin
         chk("to_bus_req_high", a_bus_req, 1);
         tick();
      end
      chk("to_bus_req_low", a_bus_req, 0);
      chk("to_rsp_valid", a_rsp_valid, 1);
      chk("to_rsp_err", a_rsp_err, 2);
      chk("to_rsp_data", a_rsp_data, 0);
      tick();

      // ack arriving in the 4th wait cycle beats the timeout
      req_a(0, MEM_MODE_HWORD_SIGN, 32'h12, 32'h0, 5'd6);
      tick();
      a_req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("ack4_bus_req", a_bus_req, 1);
         tick();
      end
      chk("ack4_bus_req_last", a_bus_req, 1);
      a_bus_ack = 1'b1;
      a_bus_rdata = 32'h8001_0000;
      tick();
      a_bus_ack = 1'b0;
      chk("ack4_rsp_valid", a_rsp_valid, 1);
      chk("ack4_rsp_err", a_rsp_err, 0);
      chk("ack4_rsp_data", a_rsp_data, 32'hFFFF_8001);
      tick();

      // reset pulsed mid bus cycle
      req_a(0, MEM_MODE_WORD, 32'h20, 32'h0, 5'd2);
      tick();
      a_req_valid = 1'b0;
      chk("rst_mid_bus_req", a_bus_req, 1);
      #1 reset = 1'b1;
      #1;
      chk("rst_mid_bus_drop", a_bus_req, 0);
      chk("rst_mid_rsp", a_rsp_valid, 0);
      chk("rst_mid_ready", a_req_ready, 1);
      chk("rst_mid_byteen", a_bus_byteen, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("rst_mid_after_rsp", a_rsp_valid, 0);
      chk("rst_mid_after_bus", a_bus_req, 0);

      // 64-bit: doubleword load at 0x10
      req_b(MEM_MODE_DWORD, 32'h10, 5'd11);
      tick();
      b_req_valid = 1'b0;
      chk("dw_byteen", b_bus_byteen, 8'hFF);
      chk("dw_bus_addr", b_bus_addr, 29'h2);
      b_bus_ack = 1'b1;
      b_bus_rdata = 64'h0123_4567_89AB_CDEF;
      tick();
      b_bus_ack = 1'b0;
      chk("dw_rsp_data", b_rsp_data, 64'h0123_4567_89AB_CDEF);
      chk("dw_rsp_err", b_rsp_err, 0);
      chk("dw_rsp_dst", b_rsp_dst, 11);
      tick();

      // 64-bit: word load in upper half sign-extends
      req_b(MEM_MODE_WORD, 32'h14, 5'd12);
      tick();
      b_req_valid = 1'b0;
      chk("w64_byteen", b_bus_byteen, 8'hF0);
      b_bus_ack = 1'b1;
      b_bus_rdata = 64'h8000_0000_1234_5678;
      tick();
      b_bus_ack = 1'b0;
      chk("w64_rsp_data", b_rsp_data, 64'hFFFF_FFFF_8000_0000);
      tick();

      // 64-bit: doubleword at 0x14 is misaligned, mode 6 is illegal
      req_b(MEM_MODE_DWORD, 32'h14, 5'd13);
      tick();
      b_req_valid = 1'b0;
      chk("dw_mis_err", b_rsp_err, 1);
      chk("dw_mis_no_bus", b_bus_req, 0);
      tick();
      req_b(3'd6, 32'h0, 5'd14);
      tick();
      b_req_valid = 1'b0;
      chk("m6_err", b_rsp_err, 3);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
